// File: rtl/load_unit.sv
// load_unit: MEM-stage load unit with bus handshake, lane alignment and extension.
// Define MISALIGN_SPLIT_EN to service misaligned loads (crossing ones in two beats).
module load_unit #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_msize,
  input  logic              req_unsigned,
  output logic              dbus_valid,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [2:0]        dbus_size,
  input  logic              dbus_ok,
  input  logic [DATA_W-1:0] dbus_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_misalign
);

  localparam int NB  = DATA_W / 8;
  localparam int LNB = $clog2(NB);
  localparam logic [2:0] FULL = 3'(LNB);

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
`ifdef MISALIGN_SPLIT_EN
    BEAT1,
`endif
    RESP
  } state_t;

  state_t           state;
  logic [LNB-1:0]   off_q;
  logic [2:0]       msz_q;
  logic             uns_q;

  logic [2:0]       in_msz;
  logic [LNB-1:0]   in_off;
`ifdef MISALIGN_SPLIT_EN
  logic             in_cross;
  logic             split_q;
  logic [DATA_W-1:0] beat_buf;
`else
  logic [LNB-1:0]   sz_mask;
  logic             in_mis;
`endif

  // Shift the lane pair down to the byte offset, then sign/zero extend.
  function automatic logic [DATA_W-1:0] extract(
    input logic [2*DATA_W-1:0] cat,
    input logic [LNB-1:0]      off,
    input logic [2:0]          msz,
    input logic                uns
  );
    logic [2*DATA_W-1:0] sh;
    logic [DATA_W-1:0]   r;
    logic [DATA_W-1:0]   tmp;
    logic [DATA_W-1:0]   mask;
    logic                sgn;
    int                  w;
    sh   = cat >> {off, 3'b000};
    r    = sh[DATA_W-1:0];
    w    = 8 << msz;
    tmp  = r >> (w - 1);
    sgn  = (w < DATA_W) ? (~uns & tmp[0]) : 1'b0;
    mask = (w < DATA_W) ? ({DATA_W{1'b1}} << w) : '0;
    return sgn ? (r | mask) : (r & ~mask);
  endfunction

  // Decode the incoming request: clamped size, lane offset, alignment.
  always_comb begin
    in_msz = (req_msize > FULL) ? FULL : req_msize;
    in_off = req_addr[LNB-1:0];
`ifdef MISALIGN_SPLIT_EN
    in_cross = (int'(in_off) + (1 << in_msz)) > NB;
`else
    sz_mask = LNB'((1 << in_msz) - 1);
    in_mis  = |(in_off & sz_mask);
`endif
  end

  // Load sequencer with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      dbus_valid    <= 1'b0;
      dbus_addr     <= '0;
      dbus_size     <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_misalign <= 1'b0;
      off_q         <= '0;
      msz_q         <= '0;
      uns_q         <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      split_q       <= 1'b0;
      beat_buf      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            off_q     <= in_off;
            msz_q     <= in_msz;
            uns_q     <= req_unsigned;
`ifdef MISALIGN_SPLIT_EN
            state      <= BEAT0;
            dbus_valid <= 1'b1;
            split_q    <= in_cross;
            if (in_cross) begin
              dbus_addr <= {req_addr[ADDR_W-1:LNB], {LNB{1'b0}}};
              dbus_size <= FULL;
            end else begin
              dbus_addr <= req_addr;
              dbus_size <= in_msz;
            end
`else
            if (in_mis) begin
              state         <= RESP;
              resp_valid    <= 1'b1;
              resp_misalign <= 1'b1;
              resp_data     <= '0;
            end else begin
              state      <= BEAT0;
              dbus_valid <= 1'b1;
              dbus_addr  <= req_addr;
              dbus_size  <= in_msz;
            end
`endif
          end
        end
        BEAT0: begin
          if (dbus_ok) begin
`ifdef MISALIGN_SPLIT_EN
            if (split_q) begin
              beat_buf  <= dbus_data;
              dbus_addr <= dbus_addr + ADDR_W'(NB);
              state     <= BEAT1;
            end else begin
              state         <= RESP;
              dbus_valid    <= 1'b0;
              resp_valid    <= 1'b1;
              resp_misalign <= 1'b0;
              resp_data     <= extract({{DATA_W{1'b0}}, dbus_data},
                                       off_q, msz_q, uns_q);
            end
`else
            state         <= RESP;
            dbus_valid    <= 1'b0;
            resp_valid    <= 1'b1;
            resp_misalign <= 1'b0;
            resp_data     <= extract({{DATA_W{1'b0}}, dbus_data},
                                     off_q, msz_q, uns_q);
`endif
          end
        end
`ifdef MISALIGN_SPLIT_EN
        BEAT1: begin
          if (dbus_ok) begin
            state         <= RESP;
            dbus_valid    <= 1'b0;
            resp_valid    <= 1'b1;
            resp_misalign <= 1'b0;
            resp_data     <= extract({dbus_data, beat_buf},
                                     off_q, msz_q, uns_q);
          end
        end
`endif
        RESP: begin
          state         <= IDLE;
          resp_valid    <= 1'b0;
          resp_misalign <= 1'b0;
          req_ready     <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
